stripe_sched: RTL and testbench

Round-robin scheduler that feeds the byte-striping stage of the PHY transmit path. It arbitrates among `NUM_REQ` show-ahead byte FIFOs and issues one byte per `clk_2f` cycle on `data_mux`/`valid_mux`. Grants are always a fixed even-length burst that starts on an even slot, so each pair of bytes from one requester lands on stripe 0 then stripe 1. It also honours downstream backpressure at burst boundaries.

---
 rtl/stripe_sched_pkg.sv | 18 +
 rtl/stripe_sched_rr_arb.sv | 33 +++
 rtl/stripe_sched.sv | 119 +++++++++++
 tb/tb_stripe_sched.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stripe_sched_pkg.sv
// Shared PHY definitions for the stripe scheduler: FSM encoding, byte width
// default and the index-width helper.
package stripe_sched_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    localparam int DATA_W_DEF = 8;

    // Width needed to index n items; never less than one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/stripe_sched_rr_arb.sv
// Combinational rotate-priority arbiter: first requester searching upward from
// last_grant+1, wrapping at NUM_REQ.
module rr_arb
    import stripe_sched_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]             req,
    input  logic [clog2_min1(NUM_REQ)-1:0] last_grant,
    output logic [NUM_REQ-1:0]             grant,
    output logic                           valid
);

    localparam int GW = clog2_min1(NUM_REQ);

    logic [GW-1:0] idx;

    // NOTE: every output of a combinational block gets a default first so no
    // path through the block leaves it unassigned, which would infer a latch.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = GW'((int'(last_grant) + k) % NUM_REQ);
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stripe_sched.sv
// Round-robin burst scheduler feeding the byte striper: fixed even-length grants
// aligned to even slots, one registered byte per clk_2f cycle.
module stripe_sched
    import stripe_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int BURST   = 2
) (
    input  logic                           clk_2f,
    input  logic                           reset_L,
    input  logic                           enable,
    input  logic                           pause,
    input  logic [NUM_REQ-1:0]             fifo_empty,
    input  logic [NUM_REQ*DATA_W-1:0]      fifo_data,
    output logic [NUM_REQ-1:0]             fifo_pop,
    output logic [DATA_W-1:0]              data_mux,
    output logic                           valid_mux,
    output logic [clog2_min1(NUM_REQ)-1:0] grant_id,
    output logic                           busy
);

    localparam int GW = clog2_min1(NUM_REQ);
    localparam int CW = clog2_min1(BURST);

    logic [0:0]         state;
    logic               phase;
    logic [CW-1:0]      slot_cnt;
    logic               drained;
    logic [GW-1:0]      last_grant;

    logic [NUM_REQ-1:0] win_oh;
    logic               win_valid;
    logic [GW-1:0]      win_idx;
    logic               start;
    logic               burst_pop;
    logic [GW-1:0]      sel_idx;
    logic [DATA_W-1:0]  sel_byte;
    logic [NUM_REQ-1:0] pop_vec;

    rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
        .req        (~fifo_empty),
        .last_grant (last_grant),
        .grant      (win_oh),
        .valid      (win_valid)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_oh[i]) win_idx = GW'(i);
        end
    end

    // New bursts only open on even slots so byte pairs stay stripe-aligned.
    assign start     = (state == ST_IDLE) && !phase && enable && !pause && win_valid;
    assign burst_pop = (state == ST_BURST) && !drained && !fifo_empty[grant_id];
    assign sel_idx   = (state == ST_IDLE) ? win_idx : grant_id;
    assign sel_byte  = fifo_data[sel_idx*DATA_W +: DATA_W];

    always_comb begin
        pop_vec = '0;
        if (start)          pop_vec = win_oh;
        else if (burst_pop) pop_vec[grant_id] = 1'b1;
    end

    // Reset must silence the pop at once, even though it is combinational.
    assign fifo_pop = reset_L ? pop_vec : '0;
    assign busy     = (state == ST_BURST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_2f or negedge reset_L) begin
        if (!reset_L) begin
            state      <= ST_IDLE;
            phase      <= 1'b0;
            slot_cnt   <= '0;
            drained    <= 1'b0;
            last_grant <= GW'(NUM_REQ - 1);
            grant_id   <= '0;
            data_mux   <= '0;
            valid_mux  <= 1'b0;
        end else begin
            phase <= ~phase;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        data_mux   <= sel_byte;
                        valid_mux  <= 1'b1;
                        grant_id   <= win_idx;
                        last_grant <= win_idx;
                        slot_cnt   <= CW'(1);
                        state      <= ST_BURST;
                    end else begin
                        valid_mux <= 1'b0;
                    end
                end
                default: begin
                    if (burst_pop) begin
                        data_mux  <= sel_byte;
                        valid_mux <= 1'b1;
                    end else begin
                        valid_mux <= 1'b0;
                        drained   <= 1'b1;
                    end
                    // Bursts always run to full length to keep slot parity.
                    if (slot_cnt == CW'(BURST - 1)) begin
                        slot_cnt <= '0;
                        drained  <= 1'b0;
                        state    <= ST_IDLE;
                    end else begin
                        slot_cnt <= slot_cnt + CW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stripe_sched.sv
// Scoreboard bench for stripe_sched: FIFO model drives requesters, a negedge
// monitor checks every valid byte against the expected queue and slot.
module tb_stripe_sched;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int BURST   = 2;

    typedef struct {
        logic [7:0] data;
        logic [1:0] gid;
        int         slot;
    } exp_t;

    logic        clk_2f = 1'b0;
    logic        reset_L;
    logic        enable;
    logic        pause;
    logic [3:0]  fifo_empty;
    logic [31:0] fifo_data;
    logic [3:0]  fifo_pop;
    logic [7:0]  data_mux;
    logic        valid_mux;
    logic [1:0]  grant_id;
    logic        busy;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   edge_n   = 0;
    int   base     = 0;
    bit   model_on = 1'b0;
    exp_t exp_q[$];
    logic [7:0] fq[NUM_REQ][$];
    logic [3:0] pop_s;

    stripe_sched #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .BURST(BURST)) dut (
        .clk_2f     (clk_2f),
        .reset_L    (reset_L),
        .enable     (enable),
        .pause      (pause),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_pop   (fifo_pop),
        .data_mux   (data_mux),
        .valid_mux  (valid_mux),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    always #5 clk_2f = ~clk_2f;

    // Edge index since reset release; its parity equals the DUT phase.
    always @(posedge clk_2f or negedge reset_L) begin
        if (!reset_L) edge_n <= 0;
        else          edge_n <= edge_n + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic update_io();
        for (int i = 0; i < NUM_REQ; i++) begin
            fifo_empty[i] = (fq[i].size() == 0);
            fifo_data[i*DATA_W +: DATA_W] = (fq[i].size() != 0) ? fq[i][0] : 8'h00;
        end
    endtask

    task automatic load(input int i, input logic [7:0] b);
        fq[i].push_back(b);
    endtask

    task automatic expect_byte(input logic [7:0] d, input logic [1:0] g, input int s);
        exp_t e;
        e.data = d;
        e.gid  = g;
        e.slot = s;
        exp_q.push_back(e);
    endtask

    task automatic sync_even();
        do begin
            @(posedge clk_2f);
            #2;
        end while (edge_n[0]);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(posedge clk_2f);
            n++;
        end
        check({name, "_drained"}, 32'(exp_q.size()), 0);
        repeat (2) @(posedge clk_2f);
    endtask

    // FIFO model: a pop seen during the cycle takes effect just after the edge.
    initial begin
        forever begin
            @(negedge clk_2f);
            pop_s = fifo_pop;
            @(posedge clk_2f);
            #1;
            if (model_on) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (pop_s[i]) begin
                        check("pop_from_nonempty", 32'(fq[i].size() != 0), 1);
                        if (fq[i].size() != 0) void'(fq[i].pop_front());
                    end
                end
                update_io();
            end
        end
    end

    // Monitor: every valid byte must match the scoreboard head, owner and slot.
    always @(negedge clk_2f) begin
        exp_t e;
        if (reset_L) begin
            check("pop_onehot0", 32'($onehot0(fifo_pop)), 1);
            if (!busy && fifo_pop != 4'b0) check("grant_even_phase", 32'(edge_n[0]), 0);
            if (valid_mux) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got %02h, scoreboard empty (t=%0t)", data_mux, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("byte_data", 32'(data_mux), 32'(e.data));
                    check("byte_grant_id", 32'(grant_id), 32'(e.gid));
                    check("byte_slot", 32'(edge_n - 1 - base), 32'(e.slot));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_L    = 1'b0;
        enable     = 1'b0;
        pause      = 1'b0;
        fifo_empty = '1;
        fifo_data  = '0;

        // Reset held with random inputs: every output stays at zero.
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_2f);
            #2;
            enable     = 1'($urandom);
            pause      = 1'($urandom);
            fifo_empty = 4'($urandom);
            fifo_data  = $urandom;
            @(negedge clk_2f);
            check("rst_data_mux", 32'(data_mux), 0);
            check("rst_valid_mux", 32'(valid_mux), 0);
            check("rst_fifo_pop", 32'(fifo_pop), 0);
            check("rst_grant_id", 32'(grant_id), 0);
            check("rst_busy", 32'(busy), 0);
        end
        enable   = 1'b1;
        pause    = 1'b0;
        model_on = 1'b1;
        update_io();
        @(posedge clk_2f);
        #2;
        reset_L = 1'b1;

        // Fairness, loaded on an odd phase: first grant waits for the even slot.
        @(posedge clk_2f);
        #2;
        for (int i = 0; i < NUM_REQ; i++)
            for (int j = 0; j < 4; j++) load(i, 8'(8'h40 + i*16 + j));
        update_io();
        #1;
        check("no_grant_odd_phase", 32'(fifo_pop), 0);
        base = edge_n + 1;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NUM_REQ; i++)
                for (int b = 0; b < 2; b++)
                    expect_byte(8'(8'h40 + i*16 + 2*r + b), 2'(i), r*8 + i*2 + b);
        wait_drain("fairness");

        // Single requester: back-to-back bursts with no dead slot.
        sync_even();
        base = edge_n;
        load(2, 8'hA0); load(2, 8'hA1); load(2, 8'hA2); load(2, 8'hA3);
        update_io();
        expect_byte(8'hA0, 2'd2, 0);
        expect_byte(8'hA1, 2'd2, 1);
        expect_byte(8'hA2, 2'd2, 2);
        expect_byte(8'hA3, 2'd2, 3);
        wait_drain("single");
        check("idle_busy", 32'(busy), 0);

        // Short requester: bubble fills the rest of its burst.
        sync_even();
        base = edge_n;
        load(1, 8'hB0);
        load(2, 8'hC0); load(2, 8'hC1);
        update_io();
        expect_byte(8'hB0, 2'd1, 0);
        expect_byte(8'hC0, 2'd2, 2);
        expect_byte(8'hC1, 2'd2, 3);
        wait_drain("short");

        // Pause raised in slot 1: burst completes, next grant after release.
        sync_even();
        base = edge_n;
        load(0, 8'hD0); load(0, 8'hD1); load(0, 8'hD2); load(0, 8'hD3);
        update_io();
        expect_byte(8'hD0, 2'd0, 0);
        expect_byte(8'hD1, 2'd0, 1);
        expect_byte(8'hD2, 2'd0, 6);
        expect_byte(8'hD3, 2'd0, 7);
        @(posedge clk_2f);
        #2;
        pause = 1'b1;
        check("pause_burst_busy", 32'(busy), 1);
        @(posedge clk_2f);
        #2;
        check("pause_blocks_grant", 32'(fifo_pop), 0);
        repeat (3) @(posedge clk_2f);
        #2;
        pause = 1'b0;
        #1;
        check("no_grant_odd_after_pause", 32'(fifo_pop), 0);
        wait_drain("pause");

        // Mid-burst reset: outputs clear at once, then req 0 wins first.
        sync_even();
        base = edge_n;
        load(0, 8'hF0); load(0, 8'hF1);
        load(2, 8'hE0); load(2, 8'hE1);
        update_io();
        @(posedge clk_2f);
        #2;
        check("midrst_in_burst", 32'(busy), 1);
        check("midrst_pop_pending", 32'(fifo_pop), 32'h4);
        reset_L = 1'b0;
        #1;
        check("midrst_valid", 32'(valid_mux), 0);
        check("midrst_pop", 32'(fifo_pop), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_grant_id", 32'(grant_id), 0);
        for (int i = 0; i < NUM_REQ; i++) fq[i].delete();
        update_io();
        repeat (2) @(posedge clk_2f);
        #2;
        reset_L = 1'b1;
        base = edge_n;
        load(0, 8'hF0); load(0, 8'hF1);
        load(2, 8'hE0); load(2, 8'hE1);
        update_io();
        expect_byte(8'hF0, 2'd0, 0);
        expect_byte(8'hF1, 2'd0, 1);
        expect_byte(8'hE0, 2'd2, 2);
        expect_byte(8'hE1, 2'd2, 3);
        wait_drain("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
